// File: rtl/matrix_multiply_sequencer_pkg.sv
// Shared constants, state encoding and packing helper for the 3x3 matrix multiply sequencer.
package matrix_mult_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned N      = 3;
  localparam int unsigned NELEM  = N * N;
  localparam int unsigned BUS_W  = ELEM_W * NELEM;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // LSB position of element k on a packed bus; element 0 occupies the MSBs.
  function automatic int unsigned idx_to_lsb(input int unsigned k);
    return BUS_W - ELEM_W * (k + 1);
  endfunction

endpackage

// File: rtl/matrix_multiply_sequencer_if.sv
// Valid/ready operand and result streams of the matrix multiply sequencer.
interface matrix_multiply_sequencer_if;
  import matrix_mult_pkg::*;

  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/matrix_multiply_sequencer_core.sv
// Combinational 3x3 matrix multiply, C = A x B, all arithmetic modulo 2^16.
module matrix_multiply_3x3_core
  import matrix_mult_pkg::*;
(
  input  logic [BUS_W-1:0] a_bus,
  input  logic [BUS_W-1:0] b_bus,
  output logic [BUS_W-1:0] c_bus
);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [ELEM_W-1:0] p0, p1, p2;

      // Products kept at element width so every term wraps like the sum.
      assign p0 = a_bus[idx_to_lsb(gi*N + 0) +: ELEM_W] * b_bus[idx_to_lsb(0*N + gj) +: ELEM_W];
      assign p1 = a_bus[idx_to_lsb(gi*N + 1) +: ELEM_W] * b_bus[idx_to_lsb(1*N + gj) +: ELEM_W];
      assign p2 = a_bus[idx_to_lsb(gi*N + 2) +: ELEM_W] * b_bus[idx_to_lsb(2*N + gj) +: ELEM_W];
      assign c_bus[idx_to_lsb(gi*N + gj) +: ELEM_W] = p0 + p1 + p2;
    end
  end

endmodule

// File: rtl/matrix_multiply_sequencer.sv
// Loads two 3x3 operand matrices from a word stream, multiplies once, streams nine results out.
module matrix_multiply_sequencer
  import matrix_mult_pkg::*;
(
  input  logic                         system1000,
  input  logic                         system1000_rstn,
  input  logic                         clear,
  matrix_multiply_sequencer_if.slave   bus,
  output logic                         busy
);

  localparam logic [BUS_W-1:0] ELEM_MASK = {{(BUS_W-ELEM_W){1'b0}}, {ELEM_W{1'b1}}};

  state_t            state, state_next;
  logic [4:0]        load_cnt;
  logic [3:0]        drain_cnt;
  logic [BUS_W-1:0]  a_reg, b_reg, c_reg, c_bus;
  logic              in_ready, out_valid;
  logic              in_fire, out_fire;
  int unsigned       wr_lsb, rd_lsb;

  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid && bus.out_ready;

  // Write position for the current load word; words 0..8 go to A, 9..17 to B.
  always_comb begin
    wr_lsb = '0;
    if (load_cnt < 5'd9) wr_lsb = idx_to_lsb(32'(load_cnt));
    else                 wr_lsb = idx_to_lsb(32'(load_cnt) - 32'd9);
    rd_lsb = idx_to_lsb(32'(drain_cnt));
  end

  // State register.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) state <= LOAD;
    else                  state <= state_next;
  end

  // Next-state and handshake outputs; clear overrides every transition.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire && load_cnt == 5'd17) state_next = COMPUTE;
      end
      COMPUTE: state_next = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && drain_cnt == 4'd8) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
    if (clear) state_next = LOAD;
  end

  // Counters, operand capture and result capture.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      load_cnt  <= '0;
      drain_cnt <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
    end else if (clear) begin
      load_cnt  <= '0;
      drain_cnt <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
    end else begin
      if (in_fire) begin
        if (load_cnt < 5'd9)
          a_reg <= (a_reg & ~(ELEM_MASK << wr_lsb)) | (BUS_W'(bus.in_data) << wr_lsb);
        else
          b_reg <= (b_reg & ~(ELEM_MASK << wr_lsb)) | (BUS_W'(bus.in_data) << wr_lsb);
        load_cnt <= (load_cnt == 5'd17) ? '0 : load_cnt + 5'd1;
      end
      if (state == COMPUTE) c_reg <= c_bus;
      if (out_fire) drain_cnt <= (drain_cnt == 4'd8) ? '0 : drain_cnt + 4'd1;
    end
  end

  // Core sits directly between the operand and result registers.
  matrix_multiply_3x3_core u_core (
    .a_bus (a_reg),
    .b_bus (b_reg),
    .c_bus (c_bus)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = (state == DRAIN) ? ELEM_W'(c_reg >> rd_lsb) : '0;
  assign busy          = !(state == LOAD && load_cnt == 5'd0);

endmodule

// File: tb/tb_matrix_multiply_sequencer.sv
// Scoreboard bench: the driver pushes hand-computed results, a monitor pops them on each output handshake.
module tb_matrix_multiply_sequencer;
  import matrix_mult_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  logic busy;
  logic bp = 1'b0;

  matrix_multiply_sequencer_if bus ();

  matrix_multiply_sequencer dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clear           (clear),
    .bus             (bus.slave),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_seen = 0;
  logic [15:0] exp_q[$];

  localparam logic [143:0] M_I    = {16'd1,16'd0,16'd0, 16'd0,16'd1,16'd0, 16'd0,16'd0,16'd1};
  localparam logic [143:0] M_SEQ  = {16'd1,16'd2,16'd3, 16'd4,16'd5,16'd6, 16'd7,16'd8,16'd9};
  localparam logic [143:0] M_REV  = {16'd9,16'd8,16'd7, 16'd6,16'd5,16'd4, 16'd3,16'd2,16'd1};
  localparam logic [143:0] M_GEN  = {16'd30,16'd24,16'd18, 16'd84,16'd69,16'd54, 16'd138,16'd114,16'd90};
  localparam logic [143:0] M_TWO  = {9{16'd2}};
  localparam logic [143:0] M_THR  = {9{16'd3}};
  localparam logic [143:0] M_18   = {9{16'd18}};
  localparam logic [143:0] M_256  = {16'd256, {8{16'd0}}};
  localparam logic [143:0] M_NEG  = {16'hFFFF, {8{16'd0}}};
  localparam logic [143:0] M_ONE0 = {16'd1, {8{16'd0}}};
  localparam logic [143:0] M_ZERO = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] elem(input logic [143:0] m, input int k);
    return 16'(m >> (128 - 16*k));
  endfunction

  // Sink readiness: held high, or toggled every cycle while bp is set.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready = bp ? ~bus.out_ready : 1'b1;
    end
  end

  // Monitor: samples mid-low-phase, compares every handshake and every stall hold.
  initial begin
    logic stall;
    logic [15:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn || clear) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_data", 32'(bus.out_data), 32'(held));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%0h expected no output at %0t", bus.out_data, $time);
          end else begin
            check("result", 32'(bus.out_data), 32'(exp_q.pop_front()));
          end
          out_seen++;
          stall = 1'b0;
        end else if (bus.out_valid) begin
          stall = 1'b1;
          held  = bus.out_data;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_word(input logic [15:0] d, input logic with_clear);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    clear        = with_clear;
    #2;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 at %0t", $time);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic send_op(input logic [143:0] a, input logic [143:0] b, input logic [143:0] c);
    for (int k = 0; k < 9; k++) exp_q.push_back(elem(c, k));
    for (int k = 0; k < 9; k++) send_word(elem(a, k), 1'b0);
    for (int k = 0; k < 9; k++) send_word(elem(b, k), 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d pending expected 0 at %0t", exp_q.size(), $time);
    end
  endtask

  initial begin
    int n;
    int base;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Identity
    send_op(M_I, M_SEQ, M_SEQ);
    wait_idle();

    // Uniform with latency check
    send_op(M_TWO, M_THR, M_18);
    #1;
    check("compute_out_valid", 32'(bus.out_valid), 32'd0);
    check("compute_in_ready", 32'(bus.in_ready), 32'd0);
    check("compute_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("drain_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    wait_idle();

    // General and wrap cases
    send_op(M_SEQ, M_REV, M_GEN);
    wait_idle();
    send_op(M_256, M_256, M_ZERO);
    wait_idle();
    send_op(M_NEG, M_NEG, M_ONE0);
    wait_idle();

    // Backpressure: in_ready must not return until all nine are accepted
    bp = 1'b1;
    base = out_seen;
    send_op(M_SEQ, M_REV, M_GEN);
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("bp_ready_return", 32'(bus.in_ready), 32'd1);
    check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("bp_output_count", 32'(out_seen - base), 32'd9);
    bp = 1'b0;
    @(negedge clk);

    // Reset after 10 inputs
    for (int k = 0; k < 9; k++) send_word(elem(M_SEQ, k), 1'b0);
    send_word(16'd7, 1'b0);
    rstn = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_op(M_SEQ, M_REV, M_GEN);
    wait_idle();

    // Clear at drain count 4
    base = out_seen;
    send_op(M_TWO, M_THR, M_18);
    n = 0;
    while (out_seen != base + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("clr_drain_pos", 32'(out_seen - base), 32'd4);
    clear = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_in_ready", 32'(bus.in_ready), 32'd1);
    check("clr_out_valid", 32'(bus.out_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    send_op(M_I, M_SEQ, M_SEQ);
    wait_idle();

    // Clear coinciding with the 18th input handshake
    for (int k = 0; k < 9; k++) send_word(elem(M_TWO, k), 1'b0);
    for (int k = 0; k < 8; k++) send_word(elem(M_THR, k), 1'b0);
    send_word(elem(M_THR, 8), 1'b1);
    #1;
    check("sim_busy", 32'(busy), 32'd0);
    check("sim_in_ready", 32'(bus.in_ready), 32'd1);
    check("sim_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("sim_no_output", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    send_op(M_SEQ, M_REV, M_GEN);
    wait_idle();

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
